sram_bank_arbiter: RTL

Round-robin arbiter that shares one single-port SRAM bank between N_REQ requesters (butterfly units, twiddle loader, host DMA).
- Accepts at most one request per cycle and drives registered CEN/WEN/A/D to the macro.
- Returns read data to the originating requester with a one-hot rvalid after fixed latency.
- Replaces static select-driven muxing of the bank with dynamic, fair sharing.

---
 rtl/sram_arb_pkg.sv | 35 +++
 rtl/rr_priority_pick.sv | 31 +++
 rtl/sram_bank_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM bank arbiter.
// Exports: N_REQ_MAX, ID_W (requester id width), rd_tag_t (read-return tag), rr_pick (round-robin pick).
// Latency: none (types and a combinational function). Backpressure: n/a.
package sram_arb_pkg;

  localparam int N_REQ_MAX = 16;
  // Ids are sized for the largest configuration, so one tag type serves every N_REQ.
  localparam int ID_W = $clog2(N_REQ_MAX);

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } rd_tag_t;

  // One-hot round-robin pick among the lowest n bits of req.
  // Scanning from ptr modulo n is the same as rotate, find-first, unrotate.
  function automatic logic [N_REQ_MAX-1:0] rr_pick(
    input logic [N_REQ_MAX-1:0] req,
    input logic [ID_W-1:0]      ptr,
    input int                   n
  );
    logic [ID_W-1:0] idx;
    logic            found;
    rr_pick = '0;
    found   = 1'b0;
    for (int k = 0; k < N_REQ_MAX; k++) begin
      idx = ID_W'((int'(ptr) + k) % n);
      if (k < n && !found && req[idx]) begin
        rr_pick[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority picker: first requester at or after ptr (mod N_REQ) wins.
// Ports: req/ptr in; gnt one-hot, gnt_id encoded winner, any = at least one request.
// Latency: purely combinational. Backpressure: none; output follows req every cycle.
module rr_priority_pick
  import sram_arb_pkg::*;
#(
  parameter int N_REQ = 16
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             any
);

  logic [N_REQ_MAX-1:0] req_ext;
  logic [N_REQ_MAX-1:0] pick;

  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = req;
    pick                 = rr_pick(req_ext, ptr, N_REQ);
    gnt                  = pick[N_REQ-1:0];
    gnt_id               = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick[i]) gnt_id = ID_W'(i);
    end
    any = |req;
  end

endmodule

// File: rtl/sram_bank_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM bank among N_REQ requesters.
// Ports: req/we/addr/wdata per requester, gnt (comb), rvalid/rdata return, CEN/WEN/A/D/Q macro side.
// Latency: gnt combinational, command registered (+1), read return at +1+RD_LAT. Backpressure: req held until gnt.
// Optional: define SRAM_ARB_LOCK_EN to add lock[N_REQ] (last winner keeps the bank while req&lock).
`ifndef MA_width
`define MA_width 10
`endif
`ifndef D_width
`define D_width 16
`endif

module sram_bank_arbiter
  import sram_arb_pkg::*;
#(
  parameter int N_REQ  = 16,
  parameter int MA_W   = `MA_width,
  parameter int D_W    = `D_width,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      we,
  input  logic [N_REQ*MA_W-1:0] addr,
  input  logic [N_REQ*D_W-1:0]  wdata,
`ifdef SRAM_ARB_LOCK_EN
  input  logic [N_REQ-1:0]      lock,
`endif
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      rvalid,
  output logic [D_W-1:0]        rdata,
  output logic                  CEN,
  output logic                  WEN,
  output logic [MA_W-1:0]       A,
  output logic [D_W-1:0]        D,
  input  logic [D_W-1:0]        Q
);

  logic [ID_W-1:0]  ptr;
  logic [N_REQ-1:0] rr_gnt;
  logic [ID_W-1:0]  rr_id;
  logic             rr_any;
  logic [ID_W-1:0]  gnt_id;
  logic             accept;
  logic             hold;

  logic             sel_we;
  logic [MA_W-1:0]  sel_addr;
  logic [D_W-1:0]   sel_wdata;

  rd_tag_t tag_pipe [RD_LAT+1];

  rr_priority_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .gnt    (rr_gnt),
    .gnt_id (rr_id),
    .any    (rr_any)
  );

`ifdef SRAM_ARB_LOCK_EN
  logic            last_vld;
  logic [ID_W-1:0] last_id;

  // The most recent winner keeps the bank while it still requests with lock set.
  always_comb begin
    hold = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (last_vld && last_id == ID_W'(i) && req[i] && lock[i]) hold = 1'b1;
    end
  end

  always_comb begin
    gnt    = rr_gnt;
    gnt_id = rr_id;
    accept = rr_any;
    if (hold) begin
      gnt_id = last_id;
      accept = 1'b1;
      for (int i = 0; i < N_REQ; i++) gnt[i] = (last_id == ID_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_vld <= 1'b0;
      last_id  <= '0;
    end else if (accept) begin
      last_vld <= 1'b1;
      last_id  <= gnt_id;
    end
  end
`else
  assign hold   = 1'b0;
  assign gnt    = rr_gnt;
  assign gnt_id = rr_id;
  assign accept = rr_any;
`endif

  // Winner's operands; gnt is one-hot so at most one term contributes.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_we    = we[i];
        sel_addr  = addr[i*MA_W +: MA_W];
        sel_wdata = wdata[i*D_W +: D_W];
      end
    end
  end

  // Pointer moves past the winner; a locked re-grant leaves it where it was.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept && !hold) begin
      ptr <= (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + ID_W'(1);
    end
  end

  // Command stage. A/D hold when idle so the macro pins do not toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      CEN <= 1'b1;
      WEN <= 1'b1;
      A   <= '0;
      D   <= '0;
    end else if (accept) begin
      CEN <= 1'b0;
      WEN <= ~sel_we;
      A   <= sel_addr;
      D   <= sel_wdata;
    end else begin
      CEN <= 1'b1;
      WEN <= 1'b1;
    end
  end

  // Tag pipe: stage k is visible k+1 cycles after the accept. Stage RD_LAT
  // drives rvalid; rdata is captured from Q on the edge that loads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= RD_LAT; k++) begin
        tag_pipe[k].vld <= 1'b0;
        tag_pipe[k].id  <= '0;
      end
      rdata <= '0;
    end else begin
      tag_pipe[0].vld <= accept & ~sel_we;
      tag_pipe[0].id  <= gnt_id;
      for (int k = 1; k <= RD_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
      if (tag_pipe[RD_LAT-1].vld) rdata <= Q;
    end
  end

  always_comb begin
    rvalid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (tag_pipe[RD_LAT].vld && tag_pipe[RD_LAT].id == ID_W'(i)) rvalid[i] = 1'b1;
    end
  end

endmodule
